// File: rtl/montgomery_mult_param.sv
// Constant-time radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// Every add is done over a narrow ADD_W-bit chunked adder with a held carry, so the
// operand width and the adder width are independent.
module montgomery_mult_param #(
   parameter int unsigned WIDTH = 1024,
   parameter int unsigned ADD_W = 128
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             err
);

   localparam int unsigned NCH = (WIDTH + 2 + ADD_W - 1) / ADD_W;
   localparam int unsigned CW  = NCH * ADD_W;
   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned BW  = $clog2(WIDTH);

   typedef enum logic [2:0] {
      StIdle, StLoad, StAddB, StAddM, StShift, StSub, StDone
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [CW-1:0]    b_q, b_d;
   logic [CW-1:0]    m_q, m_d;
   logic [CW-1:0]    c_q, c_d;
   logic [CW-1:0]    d_q, d_d;
   logic             cy_q, cy_d;
   logic             msel_q, msel_d;
   logic [CHW-1:0]   chunk_q, chunk_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic [31:0]      base;
   logic             last_chunk;
   logic [ADD_W-1:0] c_chunk, m_chunk, op_chunk;
   logic [ADD_W:0]   sum, diff;

   // Chunk datapath: shared adder/subtractor slice selected by the chunk counter
   always_comb begin
      base       = 32'(chunk_q) * 32'(ADD_W);
      last_chunk = (chunk_q == CHW'(NCH - 1));
      c_chunk    = c_q[base +: ADD_W];
      m_chunk    = m_q[base +: ADD_W];
      op_chunk   = '0;
      if (state_q == StAddB && a_q[0]) begin
         op_chunk = b_q[base +: ADD_W];
      end else if (state_q == StAddM && msel_q) begin
         op_chunk = m_chunk;
      end
      // Zero-add still runs when the selected bit is 0, keeping timing data-independent
      sum  = {1'b0, c_chunk} + {1'b0, op_chunk} + {{ADD_W{1'b0}}, cy_q};
      diff = {1'b0, c_chunk} - {1'b0, m_chunk} - {{ADD_W{1'b0}}, cy_q};
   end

   // Next-state logic for the sequencer and all datapath registers
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      c_d      = c_q;
      d_d      = d_q;
      cy_d     = cy_q;
      msel_d   = msel_q;
      chunk_d  = chunk_q;
      bit_d    = bit_q;
      err_d    = err_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = in_a;
               b_d     = CW'(in_b);
               m_d     = CW'(in_m);
               c_d     = '0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            chunk_d = '0;
            cy_d    = 1'b0;
            bit_d   = '0;
            if (!m_q[0]) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = StDone;
            end else begin
               err_d   = 1'b0;
               state_d = StAddB;
            end
         end
         StAddB: begin
            c_d[base +: ADD_W] = sum[ADD_W-1:0];
            cy_d               = sum[ADD_W];
            if (last_chunk) begin
               chunk_d = '0;
               cy_d    = 1'b0;
               // c_d already holds the fully updated C, so bit 0 is final here
               msel_d  = c_d[0];
               state_d = StAddM;
            end else begin
               chunk_d = chunk_q + CHW'(1);
            end
         end
         StAddM: begin
            c_d[base +: ADD_W] = sum[ADD_W-1:0];
            cy_d               = sum[ADD_W];
            if (last_chunk) begin
               chunk_d = '0;
               cy_d    = 1'b0;
               state_d = StShift;
            end else begin
               chunk_d = chunk_q + CHW'(1);
            end
         end
         StShift: begin
            c_d = c_q >> 1;
            a_d = a_q >> 1;
            if (bit_q == BW'(WIDTH - 1)) begin
               state_d = StSub;
            end else begin
               bit_d   = bit_q + BW'(1);
               state_d = StAddB;
            end
         end
         StSub: begin
            d_d[base +: ADD_W] = diff[ADD_W-1:0];
            cy_d               = diff[ADD_W];
            if (last_chunk) begin
               // Final borrow means C < M, so C is already reduced
               result_d = diff[ADD_W] ? c_q[WIDTH-1:0] : d_d[WIDTH-1:0];
               chunk_d  = '0;
               cy_d     = 1'b0;
               state_d  = StDone;
            end else begin
               chunk_d = chunk_q + CHW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers, cleared by the asynchronous reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         c_q      <= '0;
         d_q      <= '0;
         cy_q     <= 1'b0;
         msel_q   <= 1'b0;
         chunk_q  <= '0;
         bit_q    <= '0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         c_q      <= c_d;
         d_q      <= d_d;
         cy_q     <= cy_d;
         msel_q   <= msel_d;
         chunk_q  <= chunk_d;
         bit_q    <= bit_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   // Status outputs decoded from the registered state
   always_comb begin
      busy   = (state_q != StIdle);
      done   = (state_q == StDone);
      err    = done & err_q;
      result = result_q;
   end

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Directed bench for montgomery_mult_param: a WIDTH=8/ADD_W=4 instance for hand-computed
// vectors and protocol corners, plus a WIDTH=16/ADD_W=5 instance against a modular model.
module tb_montgomery_mult_param;

   localparam int LAT8  = 61;   // 2 + 8*(2*3+1) + 3
   localparam int LAT16 = 150;  // 2 + 16*(2*4+1) + 4

   logic        clk = 1'b0;
   logic        resetn = 1'b0;

   logic        start = 1'b0;
   logic [7:0]  a = '0, b = '0, m = '0;
   logic [7:0]  result;
   logic        done, busy, err;

   logic        start2 = 1'b0;
   logic [15:0] a2 = '0, b2 = '0, m2 = '0;
   logic [15:0] result2;
   logic        done2, busy2, err2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   montgomery_mult_param #(.WIDTH(8), .ADD_W(4)) dut8 (
      .clk(clk), .resetn(resetn), .start(start), .in_a(a), .in_b(b), .in_m(m),
      .result(result), .done(done), .busy(busy), .err(err)
   );

   montgomery_mult_param #(.WIDTH(16), .ADD_W(5)) dut16 (
      .clk(clk), .resetn(resetn), .start(start2), .in_a(a2), .in_b(b2), .in_m(m2),
      .result(result2), .done(done2), .busy(busy2), .err(err2)
   );

   // Reference: a*b*inv(2^16) mod m, with inv(2) = (m+1)/2 for odd m
   function automatic longint unsigned mont_ref(input longint unsigned x, y, md);
      longint unsigned inv2, r;
      inv2 = (md + 1) / 2;
      r = 1;
      for (int i = 0; i < 16; i++) r = (r * inv2) % md;
      return (((x * y) % md) * r) % md;
   endfunction

   // Present operands for one cycle; returns just after the accepting edge (cycle 1)
   task automatic launch(input logic [7:0] ia, ib, im);
      @(negedge clk);
      a = ia; b = ib; m = im; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Returns the cycle (relative to accept) in which done was seen, sampled at negedge
   task automatic wait_done(output int n);
      n = 1;
      @(negedge clk);
      while (done !== 1'b1 && n < LAT8 + 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (result !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset8: result=%0d done=%b busy=%b err=%b, want 0/0/0/0",
                  result, done, busy, err);
      end
      checks++;
      if (result2 !== 16'd0 || done2 !== 1'b0 || busy2 !== 1'b0 || err2 !== 1'b0) begin
         failures++;
         $display("FAIL reset16: result=%0d done=%b busy=%b err=%b, want 0/0/0/0",
                  result2, done2, busy2, err2);
      end
      @(negedge clk) resetn = 1'b1;
   endtask

   task automatic test_mult();
      logic [7:0] va [5] = '{8'd5, 8'd12, 8'd0, 8'd254, 8'd100};
      logic [7:0] vb [5] = '{8'd7, 8'd12, 8'd9, 8'd254, 8'd200};
      logic [7:0] vm [5] = '{8'd13, 8'd13, 8'd13, 8'd255, 8'd251};
      logic [7:0] ve [5] = '{8'd1, 8'd3, 8'd0, 8'd1, 8'd235};
      int n;
      for (int i = 0; i < 5; i++) begin
         launch(va[i], vb[i], vm[i]);
         wait_done(n);
         checks++;
         if (n !== LAT8) begin
            failures++;
            $display("FAIL mult_lat[%0d]: done at cycle %0d, want %0d", i, n, LAT8);
         end
         checks++;
         if (result !== ve[i]) begin
            failures++;
            $display("FAIL mult_result[%0d]: got %0d, want %0d", i, result, ve[i]);
         end
         checks++;
         if (err !== 1'b0) begin
            failures++;
            $display("FAIL mult_err[%0d]: got %b, want 0", i, err);
         end
      end
   endtask

   task automatic test_even_m();
      launch(8'd3, 8'd4, 8'd12);
      @(negedge clk);  // cycle 1
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL even_c1: busy=%b done=%b, want 1/0", busy, done);
      end
      @(negedge clk);  // cycle 2
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL even_c2: done=%b err=%b busy=%b, want 1/1/1", done, err, busy);
      end
      checks++;
      if (result !== 8'd0) begin
         failures++;
         $display("FAIL even_result: got %0d, want 0", result);
      end
      @(negedge clk);  // cycle 3
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL even_c3: busy=%b done=%b err=%b, want 0/0/0", busy, done, err);
      end
   endtask

   task automatic test_ignored_start();
      int n;
      launch(8'd5, 8'd7, 8'd13);
      n = 1;
      @(negedge clk);
      while (done !== 1'b1 && n < LAT8 + 20) begin
         if (n == 20) begin
            start = 1'b1; a = 8'd100; b = 8'd200; m = 8'd251;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      checks++;
      if (n !== LAT8) begin
         failures++;
         $display("FAIL ignored_lat: done at cycle %0d, want %0d", n, LAT8);
      end
      checks++;
      if (result !== 8'd1) begin
         failures++;
         $display("FAIL ignored_result: got %0d, want 1", result);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      launch(8'd12, 8'd12, 8'd13);
      wait_done(n);
      checks++;
      if (n !== LAT8 || result !== 8'd3) begin
         failures++;
         $display("FAIL b2b_first: cycle %0d result %0d, want %0d/3", n, result, LAT8);
      end
      // Start held in the done cycle must be ignored
      start = 1'b1; a = 8'd100; b = 8'd200; m = 8'd251;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_busy_fall: busy=%b, want 0", busy);
      end
      a = 8'd0; b = 8'd9; m = 8'd13;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(n);
      checks++;
      if (n !== LAT8) begin
         failures++;
         $display("FAIL b2b_lat: done at cycle %0d, want %0d", n, LAT8);
      end
      checks++;
      if (result !== 8'd0) begin
         failures++;
         $display("FAIL b2b_result: got %0d, want 0", result);
      end
   endtask

   task automatic test_reset_midrun();
      int n;
      int seen;
      launch(8'd100, 8'd200, 8'd251);
      wait_done(n);
      checks++;
      if (result !== 8'd235) begin
         failures++;
         $display("FAIL rst_pre: got %0d, want 235", result);
      end
      launch(8'd5, 8'd7, 8'd13);
      repeat (30) @(negedge clk);  // cycle 30
      resetn = 1'b0;
      #1;
      checks++;
      if (result !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid: result=%0d done=%b busy=%b err=%b, want 0/0/0/0",
                  result, done, busy, err);
      end
      @(negedge clk) resetn = 1'b1;
      seen = 0;
      repeat (LAT8 + 5) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL rst_no_done: %0d active cycles after reset, want 0", seen);
      end
      launch(8'd254, 8'd254, 8'd255);
      wait_done(n);
      checks++;
      if (n !== LAT8 || result !== 8'd1) begin
         failures++;
         $display("FAIL rst_after: cycle %0d result %0d, want %0d/1", n, result, LAT8);
      end
   endtask

   task automatic test_random16();
      longint unsigned ra, rb, rm, exp;
      int n;
      for (int i = 0; i < 20; i++) begin
         rm = longint'($urandom_range(65535, 3)) | 1;
         ra = longint'($urandom) % rm;
         rb = longint'($urandom) % rm;
         exp = mont_ref(ra, rb, rm);
         @(negedge clk);
         a2 = ra[15:0]; b2 = rb[15:0]; m2 = rm[15:0]; start2 = 1'b1;
         @(posedge clk);
         #1 start2 = 1'b0;
         n = 1;
         @(negedge clk);
         while (done2 !== 1'b1 && n < LAT16 + 20) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n !== LAT16) begin
            failures++;
            $display("FAIL rand16_lat[%0d]: done at cycle %0d, want %0d", i, n, LAT16);
         end
         checks++;
         if (result2 !== exp[15:0] || err2 !== 1'b0) begin
            failures++;
            $display("FAIL rand16_result[%0d]: a=%0d b=%0d m=%0d got %0d err=%b, want %0d",
                     i, ra, rb, rm, result2, err2, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_even_m();
      test_ignored_start();
      test_back_to_back();
      test_reset_midrun();
      test_random16();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
